// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC packet types and helpers
package noc_pkg;

    localparam int PKT_WIDTH = 33;

    typedef logic [PKT_WIDTH-1:0] packet_t;

    // Output stage occupancy; FULL is exactly out_valid=1
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Index width that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate / priority-encode / rotate-back picker
module rr_pick
    import noc_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  winner,
    output logic            any_grant
);

    logic [NREQ-1:0] rot;
    logic            found;
    int              off;
    int              w_int;

    // Rotate so ptr sits at bit 0, take the lowest set bit, map it back
    always_comb begin
        rot   = '0;
        found = 1'b0;
        off   = 0;
        for (int j = 0; j < NREQ; j++) begin
            rot[j] = req[(j + int'(ptr)) % NREQ];
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                off   = j;
            end
        end
        w_int     = (off + int'(ptr)) % NREQ;
        any_grant = enable && found;
        winner    = IDW'(w_int);
        grant     = '0;
        if (any_grant) begin
            grant[w_int] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_output_arbiter.sv
// rtl/rr_output_arbiter.sv - N-way round-robin arbiter into a registered output stage
module rr_output_arbiter
    import noc_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = PKT_WIDTH,
    parameter int IDW   = clog2_min1(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [IDW-1:0]        out_src,
    input  logic                  out_ready
);

    out_state_t      state;
    out_state_t      state_next;
    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  winner;
    logic            any_grant;
    logic            can_load;

    assign out_valid = (state == OUT_FULL);
    // Load is possible when empty or when the current packet leaves this edge
    assign can_load  = !out_valid || out_ready;

    // Reset gates the enable so req_ready is forced low while reset is high
    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .enable    (can_load && !reset),
        .grant     (grant),
        .winner    (winner),
        .any_grant (any_grant)
    );

    assign req_ready = grant;

    // Next occupancy: a grant always fills, a drain without grant empties
    always_comb begin
        state_next = state;
        if (any_grant) begin
            state_next = OUT_FULL;
        end else if (state == OUT_FULL && out_ready) begin
            state_next = OUT_EMPTY;
        end
    end

    // Occupancy register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Payload, source tag and rotating priority move only on a grant
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
            out_src  <= '0;
            rr_ptr   <= '0;
        end else if (any_grant) begin
            out_data <= req_data[int'(winner)*WIDTH +: WIDTH];
            out_src  <= winner;
            rr_ptr   <= (int'(winner) == NREQ - 1) ? '0 : winner + IDW'(1);
        end
    end

endmodule

// File: tb/tb_rr_output_arbiter.sv
// tb/tb_rr_output_arbiter.sv - self-checking bench for rr_output_arbiter
module tb_rr_output_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 33;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [IDW-1:0]        out_src;
    logic                  out_ready;

    int checks   = 0;
    int failures = 0;

    // Reference model state: output register contents and next-priority source
    bit               m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_src;
    int               m_ptr;
    int               m_win;

    rr_output_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr, input bit can);
        int i;
        if (!can) return -1;
        for (int k = 0; k < NREQ; k++) begin
            i = (ptr + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int w);
        logic [NREQ-1:0] r;
        r = '0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        m_win = reset ? -1 : pick(req_valid, m_ptr, !m_valid || out_ready);
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0;
        end else if (m_win >= 0) begin
            m_data  = req_data[m_win*WIDTH +: WIDTH];
            m_src   = m_win;
            m_valid = 1;
            m_ptr   = (m_win + 1) % NREQ;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic set_data();
        for (int i = 0; i < NREQ; i++)
            req_data[i*WIDTH +: WIDTH] = WIDTH'(64'h1_A5A5_0000 + 64'(i) * 64'h111);
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '1; out_ready = 1'b1; set_data();
        #1;
        checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_src !== '0) begin failures++; $display("FAIL reset_out_src got=%0d exp=0", out_src); end
        checks++; if (dut.rr_ptr !== '0) begin failures++; $display("FAIL reset_rr_ptr got=%0d exp=0", dut.rr_ptr); end
        reset = 1'b0; req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        set_data();
        req_data[2*WIDTH +: WIDTH] = 33'h1_2345_6789;
        req_valid = 4'b0100; out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_req_ready got=%b exp=0100", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 33'h1_2345_6789) begin failures++; $display("FAIL single_out_data got=%h exp=123456789", out_data); end
        checks++; if (out_src !== 2'd2) begin failures++; $display("FAIL single_out_src got=%0d exp=2", out_src); end
        checks++; if (dut.rr_ptr !== 2'd3) begin failures++; $display("FAIL single_rr_ptr got=%0d exp=3", dut.rr_ptr); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_two_persistent();
        int exp_seq [6] = '{0, 1, 0, 1, 0, 1};
        do_reset();
        set_data();
        req_valid = 4'b0011; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || int'(out_src) != exp_seq[c] || out_data !== m_data) begin
                failures++; $display("FAIL two_src cycle=%0d got v=%b src=%0d data=%h exp v=1 src=%0d data=%h", c, out_valid, out_src, out_data, exp_seq[c], m_data);
            end
        end
    endtask

    task automatic test_all_four();
        int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        set_data();
        req_valid = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || int'(out_src) != exp_seq[c] || out_data !== m_data) begin
                failures++; $display("FAIL four_src cycle=%0d got v=%b src=%0d data=%h exp v=1 src=%0d data=%h", c, out_valid, out_src, out_data, exp_seq[c], m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] held;
        do_reset();
        set_data();
        req_valid = 4'b1111; out_ready = 1'b1;
        tick();
        tick();
        checks++; if (out_src !== 2'd1) begin failures++; $display("FAIL bp_setup_src got=%0d exp=1", out_src); end
        held = req_data[1*WIDTH +: WIDTH];
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_ready !== '0) begin failures++; $display("FAIL bp_req_ready cycle=%0d got=%b exp=0", c, req_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== held) begin
                failures++; $display("FAIL bp_frozen cycle=%0d got v=%b src=%0d data=%h exp v=1 src=1 data=%h", c, out_valid, out_src, out_data, held);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_release_ready got=%b exp=0100", req_ready); end
        tick();
        checks++; if (out_src !== 2'd2) begin failures++; $display("FAIL bp_release_src got=%0d exp=2", out_src); end
    endtask

    task automatic test_idle_resume();
        do_reset();
        set_data();
        out_ready = 1'b1;
        req_valid = 4'b1000;
        tick();
        checks++; if (out_src !== 2'd3) begin failures++; $display("FAIL idle_first_src got=%0d exp=3", out_src); end
        req_valid = '0;
        for (int c = 0; c < 5; c++) tick();
        checks++; if (out_valid !== 1'b0 || dut.rr_ptr !== 2'd0) begin
            failures++; $display("FAIL idle_state got v=%b ptr=%0d exp v=0 ptr=0", out_valid, dut.rr_ptr);
        end
        req_valid = 4'b1001;
        tick();
        checks++; if (out_src !== 2'd0) begin failures++; $display("FAIL resume_src0 got=%0d exp=0", out_src); end
        tick();
        checks++; if (out_src !== 2'd3) begin failures++; $display("FAIL resume_src3 got=%0d exp=3", out_src); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_data();
        req_valid = 4'b1111; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0 || dut.rr_ptr !== '0) begin
            failures++; $display("FAIL reset_mid got v=%b data=%h src=%0d ptr=%0d exp all 0", out_valid, out_data, out_src, dut.rr_ptr);
        end
        reset = 1'b0;
        req_valid = 4'b1010; out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL reset_mid_ready got=%b exp=0010", req_ready); end
        tick();
        checks++; if (out_src !== 2'd1) begin failures++; $display("FAIL reset_mid_src got=%0d exp=1", out_src); end
    endtask

    task automatic test_random();
        logic [63:0] r;
        int          waits [NREQ];
        do_reset();
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    r = {$urandom(), $urandom()};
                    req_data[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
                    req_valid[i] = 1'b1;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (req_ready !== onehot(pick(req_valid, m_ptr, !m_valid || out_ready))) begin
                failures++; $display("FAIL rand_req_ready cycle=%0d got=%b exp=%b", c, req_ready, onehot(pick(req_valid, m_ptr, !m_valid || out_ready)));
            end
            tick();
            if (m_win >= 0) begin
                checks++; if (waits[m_win] > NREQ - 1) begin
                    failures++; $display("FAIL rand_fairness src=%0d waited=%0d max=%0d", m_win, waits[m_win], NREQ - 1);
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (i == m_win) waits[i] = 0;
                    else if (req_valid[i]) waits[i]++;
                end
                req_valid[m_win] = 1'b0;
            end
            checks++; if (out_valid !== m_valid || (m_valid && (out_data !== m_data || int'(out_src) != m_src))) begin
                failures++; $display("FAIL rand_out cycle=%0d got v=%b data=%h src=%0d exp v=%b data=%h src=%0d", c, out_valid, out_data, out_src, m_valid, m_data, m_src);
            end
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
        m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0; m_win = -1;
        test_reset();
        test_single();
        test_two_persistent();
        test_all_four();
        test_backpressure();
        test_idle_resume();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
